// File: rtl/ultrasonic_echo_responder.sv
// ultrasonic_echo_responder
//   Emulates the sensor side of an HC-SR04-style trigger/echo ranging link.
//   A trigger pulse that is at least TRIG_MIN_US long starts a measurement.
//   After a fixed burst delay, the block raises echo for a width that encodes
//   the distance latched when the trigger fell. A hold-off period then
//   follows, and new triggers are accepted again only after it ends.
//
// Ports
//   clk            system clock
//   rst_n          synchronous active-low reset
//   trigger        trigger line from the ranging controller (asynchronous)
//   distance_cm    emulated target distance in cm, unsigned
//   object_present 1 = target present, 0 = force a timeout-width echo
//   echo           echo pulse back to the controller
//   busy           high while a measurement runs (BURST, ECHO, HOLDOFF)
//   trig_error     one-cycle pulse when a trigger was too short
//   meas_done      one-cycle pulse on the cycle that echo deasserts
module ultrasonic_echo_responder #(
   parameter int unsigned CLKS_PER_US    = 100,
   parameter int unsigned TRIG_MIN_US    = 10,
   parameter int unsigned BURST_DELAY_US = 250,
   parameter int unsigned US_PER_CM      = 58,
   parameter int unsigned MIN_CM         = 2,
   parameter int unsigned MAX_CM         = 400,
   parameter int unsigned TIMEOUT_US     = 38000,
   parameter int unsigned HOLDOFF_US     = 10000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       trigger,
   input  logic [8:0] distance_cm,
   input  logic       object_present,
   output logic       echo,
   output logic       busy,
   output logic       trig_error,
   output logic       meas_done
);

   localparam logic [31:0] CLKS_PER_US_L = 32'(CLKS_PER_US);
   localparam logic [31:0] US_PER_CM_L   = 32'(US_PER_CM);
   localparam logic [31:0] TIMEOUT_US_L  = 32'(TIMEOUT_US);
   localparam logic [8:0]  MIN_CM_L      = 9'(MIN_CM);
   localparam logic [8:0]  MAX_CM_L      = 9'(MAX_CM);

   // Last counter value of each timed state. The counter reads 0 on the
   // first cycle of a state, so a state lasting N cycles ends at N-1.
   localparam logic [31:0] TRIG_LAST    = 32'(TRIG_MIN_US * CLKS_PER_US) - 32'd1;
   localparam logic [31:0] HOLDOFF_LAST = 32'(HOLDOFF_US * CLKS_PER_US) - 32'd1;
   // The FSM sees the trig_s fall one cycle after it happens (it compares
   // against the registered value), and that cycle already counts toward
   // the burst delay. BURST therefore lasts one cycle less than the delay.
   localparam logic [31:0] BURST_LAST   = 32'(BURST_DELAY_US * CLKS_PER_US) - 32'd2;

   typedef enum logic [2:0] {
      IDLE,
      TRIG_HIGH,
      BURST,
      ECHO,
      HOLDOFF
   } stateT;

   stateT       state, stateNext;
   logic [31:0] cycleCnt, cycleCntNext;
   logic        trigMeta, trigSync, trigPrev;
   logic [8:0]  latchedCm;
   logic        latchedPresent;
   logic        latchNow;
   logic        trigErrorQ, trigErrorNext;
   logic        measDoneQ, measDoneNext;

   // Echo width derived from the values latched at trigger fall.
   logic        rangeValid;
   logic [31:0] echoUs;
   logic [31:0] echoCyc;

   always_comb begin
      rangeValid = latchedPresent && (latchedCm >= MIN_CM_L) && (latchedCm <= MAX_CM_L);
      echoUs     = rangeValid ? (32'(latchedCm) * US_PER_CM_L) : TIMEOUT_US_L;
      echoCyc    = echoUs * CLKS_PER_US_L;
   end

   // NOTE: every signal assigned here gets a default first, so no path
   // leaves a value unassigned and no latch is inferred.
   always_comb begin
      stateNext     = state;
      cycleCntNext  = cycleCnt;
      latchNow      = 1'b0;
      trigErrorNext = 1'b0;
      measDoneNext  = 1'b0;

      case (state)
         IDLE: begin
            // Only a real 0->1 transition counts. A trigger that is still high
            // when the FSM returns here has trigPrev=1 and is ignored.
            if (trigSync && !trigPrev) begin
               stateNext = TRIG_HIGH;
            end
         end

         TRIG_HIGH: begin
            if (trigSync) begin
               // A stuck-high trigger waits here; saturate instead of wrapping.
               if (cycleCnt != '1) begin
                  cycleCntNext = cycleCnt + 32'd1;
               end
            end else if (cycleCnt >= TRIG_LAST) begin
               latchNow  = 1'b1;
               stateNext = BURST;
            end else begin
               trigErrorNext = 1'b1;
               stateNext     = IDLE;
            end
         end

         BURST: begin
            if (cycleCnt >= BURST_LAST) begin
               stateNext = ECHO;
            end else begin
               cycleCntNext = cycleCnt + 32'd1;
            end
         end

         ECHO: begin
            if (cycleCnt >= echoCyc - 32'd1) begin
               measDoneNext = 1'b1;
               stateNext    = HOLDOFF;
            end else begin
               cycleCntNext = cycleCnt + 32'd1;
            end
         end

         HOLDOFF: begin
            if (cycleCnt >= HOLDOFF_LAST) begin
               stateNext = IDLE;
            end else begin
               cycleCntNext = cycleCnt + 32'd1;
            end
         end

         default: stateNext = IDLE;
      endcase

      // A single counter serves every state; it restarts on each state entry.
      if (stateNext != state) begin
         cycleCntNext = '0;
      end
   end

   // NOTE: state is updated with non-blocking assignments so that every
   // flop samples the values from before the clock edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         cycleCnt       <= '0;
         trigMeta       <= 1'b0;
         trigSync       <= 1'b0;
         trigPrev       <= 1'b0;
         latchedCm      <= '0;
         latchedPresent <= 1'b0;
         trigErrorQ     <= 1'b0;
         measDoneQ      <= 1'b0;
      end else begin
         trigMeta   <= trigger;
         trigSync   <= trigMeta;
         trigPrev   <= trigSync;
         state      <= stateNext;
         cycleCnt   <= cycleCntNext;
         trigErrorQ <= trigErrorNext;
         measDoneQ  <= measDoneNext;
         if (latchNow) begin
            latchedCm      <= distance_cm;
            latchedPresent <= object_present;
         end
      end
   end

   // Decode echo and busy from the registered state. Because of this, a
   // reset edge drops echo immediately.
   assign echo       = (state == ECHO);
   assign busy       = (state == BURST) || (state == ECHO) || (state == HOLDOFF);
   assign trig_error = trigErrorQ;
   assign meas_done  = measDoneQ;

endmodule

// File: tb/tb_ultrasonic_echo_responder.sv
// Directed bench for ultrasonic_echo_responder. The timing parameters are
// scaled down so that the longest echo lasts a few thousand cycles:
//   CLKS_PER_US=2, TRIG_MIN_US=10 (20 cyc), BURST_DELAY_US=25 (50 cyc),
//   US_PER_CM=3 (6 cyc/cm), TIMEOUT_US=1500 (3000 cyc), HOLDOFF_US=100 (200 cyc).
// If the trigger pin is released at cycle c, trig_s falls at edge c+2,
// echo rises at c+2+50, and busy and trig_error react at c+3.
module tb_ultrasonic_echo_responder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       trigger = 1'b0;
   logic [8:0] distance_cm = 9'd10;
   logic       object_present = 1'b1;
   logic       echo, busy, trig_error, meas_done;

   int tests = 0;
   int failed = 0;

   ultrasonic_echo_responder #(
      .CLKS_PER_US(2), .TRIG_MIN_US(10), .BURST_DELAY_US(25), .US_PER_CM(3),
      .MIN_CM(2), .MAX_CM(400), .TIMEOUT_US(1500), .HOLDOFF_US(100)
   ) dut (
      .clk(clk), .rst_n(rst_n), .trigger(trigger), .distance_cm(distance_cm),
      .object_present(object_present), .echo(echo), .busy(busy),
      .trig_error(trig_error), .meas_done(meas_done)
   );

   always #5 clk = ~clk;

   // cyc = number of rising edges so far
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Negedge monitor: records edge times and pulse widths.
   bit echoPrev = 0, busyPrev = 0;
   int curWidth = 0, echoWidth = 0, echoRises = 0, echoFalls = 0;
   int echoRiseCyc = 0, echoFallCyc = 0;
   int busyRises = 0, busyRiseCyc = 0, busyFallCyc = 0;
   int trigErrHigh = 0, trigErrCyc = 0, measDoneHigh = 0, measDoneCyc = 0;

   always @(negedge clk) begin
      if (echo) curWidth = echoPrev ? curWidth + 1 : 1;
      if (echo && !echoPrev) begin echoRises++; echoRiseCyc = cyc; end
      if (!echo && echoPrev) begin echoFalls++; echoFallCyc = cyc; echoWidth = curWidth; end
      if (busy && !busyPrev) begin busyRises++; busyRiseCyc = cyc; end
      if (!busy && busyPrev) busyFallCyc = cyc;
      if (trig_error) begin trigErrHigh++; trigErrCyc = cyc; end
      if (meas_done) begin measDoneHigh++; measDoneCyc = cyc; end
      echoPrev = echo;
      busyPrev = busy;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // Advance one cycle. Inputs are driven and values read just after the
   // negedge, once the monitor has already run.
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic pulse(input int n, output int fallCyc);
      trigger = 1'b1;
      repeat (n) tick();
      trigger = 1'b0;
      fallCyc = cyc;
   endtask

   task automatic wait_falls(input int target, input int limit, output bit ok);
      int n = 0;
      while (echoFalls < target && n < limit) begin tick(); n++; end
      ok = (echoFalls >= target);
   endtask

   task automatic wait_rises(input int target, input int limit, output bit ok);
      int n = 0;
      while (echoRises < target && n < limit) begin tick(); n++; end
      ok = (echoRises >= target);
   endtask

   task automatic wait_idle(input int limit, output bit ok);
      int n = 0;
      while (busy && n < limit) begin tick(); n++; end
      ok = !busy;
   endtask

   // Run one full measurement and check the echo position, the echo width
   // and the return to idle.
   task automatic run_meas(input string name, input int trigLen, input logic [8:0] cm,
                           input logic pres, input int expW);
      int c, f0;
      bit ok;
      distance_cm    = cm;
      object_present = pres;
      f0 = echoFalls;
      pulse(trigLen, c);
      wait_falls(f0 + 1, 4000, ok);
      tests++;
      if (!ok) begin
         failed++;
         $display("FAIL %s_echo_timeout: no echo fall seen, expected width %0d", name, expW);
      end else begin
         if (echoWidth !== expW) begin
            failed++;
            $display("FAIL %s_width: got %0d expected %0d", name, echoWidth, expW);
         end
         tests++;
         if (echoRiseCyc !== c + 52) begin
            failed++;
            $display("FAIL %s_rise: got %0d expected %0d", name, echoRiseCyc, c + 52);
         end
      end
      wait_idle(400, ok);
      tests++;
      if (!ok) begin
         failed++;
         $display("FAIL %s_idle: busy got 1 expected 0", name);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      trigger = 1'b0;
      repeat (3) tick();
      tests++;
      if ({echo, busy, trig_error, meas_done} !== 4'b0000) begin
         failed++;
         $display("FAIL reset_outputs: got %b expected 0000", {echo, busy, trig_error, meas_done});
      end
      rst_n = 1'b1;
      repeat (5) tick();
      tests++;
      if ({echo, busy} !== 2'b00) begin
         failed++;
         $display("FAIL reset_idle: got %b expected 00", {echo, busy});
      end
   endtask

   task automatic test_basic();
      int c, f0, md0, te0;
      bit ok;
      distance_cm = 9'd10;
      object_present = 1'b1;
      f0 = echoFalls; md0 = measDoneHigh; te0 = trigErrHigh;
      pulse(24, c);                     // 12 us
      wait_falls(f0 + 1, 1000, ok);
      tests++;
      if (!ok) begin
         failed++;
         $display("FAIL basic_timeout: no echo fall, expected width 60");
      end
      tests++;
      if (busyRiseCyc !== c + 3) begin
         failed++;
         $display("FAIL basic_busy_rise: got %0d expected %0d", busyRiseCyc, c + 3);
      end
      tests++;
      if (echoRiseCyc !== c + 52) begin
         failed++;
         $display("FAIL basic_rise: got %0d expected %0d", echoRiseCyc, c + 52);
      end
      tests++;
      if (echoWidth !== 60) begin       // 10 cm * 3 us * 2 cyc
         failed++;
         $display("FAIL basic_width: got %0d expected 60", echoWidth);
      end
      wait_idle(400, ok);
      tests++;
      if (measDoneHigh - md0 !== 1 || measDoneCyc !== echoFallCyc) begin
         failed++;
         $display("FAIL basic_meas_done: got %0d cycles at %0d expected 1 at %0d",
                  measDoneHigh - md0, measDoneCyc, echoFallCyc);
      end
      tests++;
      if (busyFallCyc !== echoFallCyc + 200) begin
         failed++;
         $display("FAIL basic_holdoff: got %0d expected %0d", busyFallCyc, echoFallCyc + 200);
      end
      tests++;
      if (trigErrHigh !== te0) begin
         failed++;
         $display("FAIL basic_trig_error: got %0d expected %0d", trigErrHigh, te0);
      end
   endtask

   task automatic test_short_trigger();
      int c, te0, br0, er0;
      te0 = trigErrHigh; br0 = busyRises; er0 = echoRises;
      pulse(18, c);                     // 9 us
      repeat (10) tick();
      tests++;
      if (trigErrHigh - te0 !== 1 || trigErrCyc !== c + 3) begin
         failed++;
         $display("FAIL short9_trig_error: got %0d pulses at %0d expected 1 at %0d",
                  trigErrHigh - te0, trigErrCyc, c + 3);
      end
      pulse(19, c);                     // one cycle short of 10 us
      repeat (10) tick();
      tests++;
      if (trigErrHigh - te0 !== 2) begin
         failed++;
         $display("FAIL short19_trig_error: got %0d expected 2", trigErrHigh - te0);
      end
      tests++;
      if (busyRises !== br0 || echoRises !== er0) begin
         failed++;
         $display("FAIL short_no_meas: busy rises got %0d expected %0d", busyRises, br0);
      end
      run_meas("exact10us", 20, 9'd10, 1'b1, 60);
      tests++;
      if (trigErrHigh - te0 !== 2) begin
         failed++;
         $display("FAIL exact10us_trig_error: got %0d expected 2", trigErrHigh - te0);
      end
   endtask

   task automatic test_widths();
      run_meas("no_object", 24, 9'd10,  1'b0, 3000);
      run_meas("cm401",     24, 9'd401, 1'b1, 3000);
      run_meas("cm400",     24, 9'd400, 1'b1, 2400);
      run_meas("cm2",       24, 9'd2,   1'b1, 12);
      run_meas("cm1",       24, 9'd1,   1'b1, 3000);
      run_meas("cm0",       24, 9'd0,   1'b1, 3000);
   endtask

   task automatic test_retrigger();
      int c, r0, f0, te0;
      bit ok;
      distance_cm = 9'd100;
      object_present = 1'b1;
      r0 = echoRises; f0 = echoFalls; te0 = trigErrHigh;
      pulse(24, c);
      wait_rises(r0 + 1, 200, ok);
      pulse(24, c);                     // during ECHO
      wait_falls(f0 + 1, 1000, ok);
      tests++;
      if (!ok || echoWidth !== 600) begin
         failed++;
         $display("FAIL retrig_echo_width: got %0d expected 600", echoWidth);
      end
      pulse(24, c);                     // during HOLDOFF
      wait_idle(400, ok);
      tests++;
      if (!ok || busyFallCyc !== echoFallCyc + 200) begin
         failed++;
         $display("FAIL retrig_holdoff: got %0d expected %0d", busyFallCyc, echoFallCyc + 200);
      end
      repeat (100) tick();
      tests++;
      if (busy !== 1'b0 || echoRises !== r0 + 1 || trigErrHigh !== te0) begin
         failed++;
         $display("FAIL retrig_extra_meas: rises got %0d expected %0d", echoRises, r0 + 1);
      end
      // Trigger held high across the end of HOLDOFF.
      distance_cm = 9'd10;
      r0 = echoRises; f0 = echoFalls;
      pulse(24, c);
      wait_falls(f0 + 1, 1000, ok);
      trigger = 1'b1;
      wait_idle(400, ok);
      repeat (50) tick();
      tests++;
      if (busy !== 1'b0 || echoRises !== r0 + 1) begin
         failed++;
         $display("FAIL held_trigger: busy got %0b rises %0d expected 0 and %0d",
                  busy, echoRises, r0 + 1);
      end
      trigger = 1'b0;
      repeat (30) tick();
      tests++;
      if (busy !== 1'b0) begin
         failed++;
         $display("FAIL held_release: busy got %0b expected 0", busy);
      end
      run_meas("after_held", 24, 9'd10, 1'b1, 60);
   endtask

   task automatic test_reset_mid_echo();
      int c, r0, md0;
      bit ok;
      distance_cm = 9'd100;
      object_present = 1'b1;
      r0 = echoRises;
      pulse(24, c);
      wait_rises(r0 + 1, 200, ok);
      repeat (100) tick();
      md0 = measDoneHigh;
      rst_n = 1'b0;
      tick();
      tests++;
      if ({echo, busy, meas_done} !== 3'b000) begin
         failed++;
         $display("FAIL midreset_outputs: got %b expected 000", {echo, busy, meas_done});
      end
      rst_n = 1'b1;
      repeat (20) tick();
      tests++;
      if (measDoneHigh !== md0 || busy !== 1'b0) begin
         failed++;
         $display("FAIL midreset_meas_done: got %0d expected %0d", measDoneHigh, md0);
      end
      run_meas("after_reset", 24, 9'd10, 1'b1, 60);
   endtask

   task automatic test_latch();
      int c, f0;
      bit ok;
      distance_cm = 9'd10;
      object_present = 1'b1;
      f0 = echoFalls;
      pulse(24, c);
      repeat (10) tick();               // in BURST now
      distance_cm = 9'd200;
      object_present = 1'b0;
      wait_falls(f0 + 1, 1000, ok);
      tests++;
      if (!ok || echoWidth !== 60) begin
         failed++;
         $display("FAIL latch_width: got %0d expected 60", echoWidth);
      end
      wait_idle(400, ok);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_short_trigger();
      test_widths();
      test_retrigger();
      test_reset_mid_echo();
      test_latch();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/ultrasonic_echo_responder.md
Name: ultrasonic_echo_responder

Overview:
Synthesizable responder side of the HC-SR04-style trigger/echo ranging interface. It watches the trigger line driven by the proximity controller and answers with an echo pulse whose width encodes a programmed distance, as a real ultrasonic sensor does. It is used as a hardware-in-loop sensor emulator on the Basys3 and as the bench model for the rover's proximity/crash logic.

Parameters:
CLKS_PER_US, 100, clk cycles per microsecond (100 MHz board clock)
TRIG_MIN_US, 10, minimum trigger high width that starts a measurement
BURST_DELAY_US, 250, delay from trigger fall to echo rise (emulated 8-cycle 40 kHz burst)
US_PER_CM, 58, echo microseconds per cm of range (round trip)
MIN_CM, 2, smallest reportable distance
MAX_CM, 400, largest reportable distance
TIMEOUT_US, 38000, echo width reported for no object or out of range
HOLDOFF_US, 10000, dead time after echo fall before a new trigger is accepted

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
trigger  input  1  trigger line from the ranging controller (asynchronous)
distance_cm  input  9  emulated target distance, unsigned cm
object_present  input  1  1 = target present; 0 = force timeout echo
echo  output  1  echo pulse back to the controller
busy  output  1  measurement in progress (BURST, ECHO, HOLDOFF)
trig_error  output  1  one-cycle pulse: trigger high shorter than TRIG_MIN_US
meas_done  output  1  one-cycle pulse on the cycle echo deasserts

Behaviour:
- Reset and clock: one clock, clk; reset is synchronous and active-low (rst_n). While rst_n=0 at a clk edge: echo=0, busy=0, trig_error=0, meas_done=0, state=IDLE, all counters 0, synchronizer flops 0.
- Reset mid-operation (any state) -> echo drops on that edge; no meas_done.
- trigger passes a 2-flop synchronizer (trig_s); all edges below refer to trig_s (2 cycles after the pin).
- One cycle counter, cleared on every state entry; durations below are exact in clk cycles (X_US*CLKS_PER_US).
- States:
  - IDLE: on trig_s rising edge (prev 0, now 1) -> TRIG_HIGH. A trig_s already high on entry is not an edge.
  - TRIG_HIGH: count cycles while trig_s=1. No timeout; a stuck-high trigger stays here. On trig_s fall: count >= TRIG_MIN_US*CLKS_PER_US -> latch distance_cm/object_present, -> BURST; else pulse trig_error, -> IDLE.
  - BURST: BURST_DELAY_US*CLKS_PER_US cycles, echo=0, then -> ECHO with echo=1 on that edge.
  - ECHO: echo=1 for exactly W*CLKS_PER_US cycles; W = latched_cm*US_PER_CM if object_present=1 and MIN_CM <= cm <= MAX_CM, else TIMEOUT_US. Product in >=16 bits (400*58=23200); cycle count >=32 bits. On expiry echo=0, meas_done=1 for one cycle, -> HOLDOFF.
  - HOLDOFF: HOLDOFF_US*CLKS_PER_US cycles, then -> IDLE.
- busy=1 in BURST, ECHO, HOLDOFF; 0 otherwise.
- Triggers in BURST/ECHO/HOLDOFF are ignored. A trigger still high on return to IDLE must go low, then high again.
- distance_cm/object_present changes after the latch do not affect the current echo.
- distance_cm=0 or >MAX_CM gives a timeout width; the boundaries MIN_CM and MAX_CM are valid.

Test Plan:
- Reset, trigger high 12 us, distance_cm=10, object_present=1 -> echo rises 25000 cycles after trig_s fall, high exactly 58000 cycles, meas_done 1 cycle at fall, busy high through HOLDOFF (1,000,000 cycles).
- Trigger high 9 us (900 cycles) -> trig_error one pulse, echo stays 0, busy stays 0; next 10 us pulse (exactly 1000 cycles) accepted.
- object_present=0, then distance_cm=401, then distance_cm=400 -> echo widths 3,800,000, 3,800,000 and 2,320,000 cycles.
- Second trigger during ECHO and during HOLDOFF -> no effect on echo width; no extra measurement. Trigger held high across HOLDOFF end -> no measurement until low-then-high.
- rst_n=0 for 1 cycle mid-ECHO -> echo=0 on that edge, no meas_done, state IDLE; a new 12 us trigger gives a normal measurement.
- distance_cm changed from 10 to 200 during BURST -> echo width still 58000 cycles.
